// File: rtl/battle_turn_ctrl_pkg.sv
// Shared types and helpers for the combat turn scheduler: states, hero stat
// lookups, keypad action codes and victory/defeat codes.
package battle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HERO,
    S_ENEMY,
    S_EACT,
    S_CHECK,
    S_RESULT
  } state_t;

  localparam logic [4:0] KEY_ATTACK = 5'd1;
  localparam logic [4:0] KEY_DEFEND = 5'd2;

  localparam logic [1:0] VD_PLAY = 2'd0;
  localparam logic [1:0] VD_WIN  = 2'd1;
  localparam logic [1:0] VD_LOSE = 2'd2;

  // 8 + 2*id, 10..22 for ids 1..7
  function automatic logic [4:0] hero_hp_f(input logic [2:0] id);
    return 5'd8 + {1'b0, id, 1'b0};
  endfunction

  function automatic logic [4:0] hero_atk_f(input logic [2:0] id);
    return 5'd2 + {3'b000, id[1:0]};
  endfunction

  // HP counters clamp at zero instead of wrapping
  function automatic logic [4:0] sat_sub(input logic [4:0] a, input logic [4:0] b);
    return (a > b) ? (a - b) : 5'd0;
  endfunction

endpackage

// File: rtl/battle_turn_ctrl_sec_tick.sv
// Free-running one-cycle pulse every TICK_DIV clocks; never restarted by the
// turn logic, so turn lengths carry up to one tick of phase jitter.
module sec_tick #(
  parameter int TICK_DIV = 27_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == LAST);
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/battle_turn_ctrl.sv
// Combat turn scheduler: alternates hero/enemy turns, tracks both HP counters
// and reports victory/defeat on v_d. Define BATTLE_CRIT_EN for hero crits.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int TICK_DIV  = 27_000_000,
  parameter int TURN_SECS = 5,
  parameter int ENEMY_HP  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_active,
  input  logic [2:0] heroe_seleccionado,
  input  logic       keypad_pressed,
  input  logic [4:0] key,
  output logic [1:0] v_d,
  output logic [4:0] hero_hp,
  output logic [4:0] enemy_hp,
  output logic       enemy_turn,
  output logic [2:0] secs_left
);

  state_t     state_q;
  logic [1:0] v_d_q;
  logic [4:0] hero_hp_q;
  logic [4:0] enemy_hp_q;
  logic       enemy_turn_q;
  logic [2:0] secs_q;
  logic       defend_q;
  logic [2:0] hero_id_q;
  logic       ga_q;
  logic       kp_q;
  logic       key_evt_q;
  logic [4:0] key_code_q;
  logic [7:0] lfsr_q;
  logic       tick;
  logic [4:0] atk_dmg;
  logic [4:0] foe_dmg;

  sec_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tick_o (tick)
  );

  // x^8+x^6+x^5+x^4+1, advancing every cycle regardless of game state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Key edge becomes a one-cycle event, so presses outside HERO_TURN are lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_q       <= 1'b0;
      key_evt_q  <= 1'b0;
      key_code_q <= 5'd0;
      ga_q       <= 1'b0;
    end else begin
      kp_q      <= keypad_pressed;
      key_evt_q <= keypad_pressed & ~kp_q;
      ga_q      <= game_active;
      if (keypad_pressed && !kp_q) begin
        key_code_q <= key;
      end
    end
  end

`ifdef BATTLE_CRIT_EN
  assign atk_dmg = (lfsr_q[3:2] == 2'b11) ? {hero_atk_f(hero_id_q)[3:0], 1'b0}
                                          : hero_atk_f(hero_id_q);
`else
  assign atk_dmg = hero_atk_f(hero_id_q);
`endif

  assign foe_dmg = defend_q ? ((5'd2 + {3'b000, lfsr_q[1:0]}) >> 1)
                            : (5'd2 + {3'b000, lfsr_q[1:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      v_d_q        <= VD_PLAY;
      hero_hp_q    <= 5'd0;
      enemy_hp_q   <= 5'd0;
      enemy_turn_q <= 1'b0;
      secs_q       <= 3'd0;
      defend_q     <= 1'b0;
      hero_id_q    <= 3'd0;
    end else if (!game_active) begin
      // HP values are left visible after the game FSM leaves play
      state_q      <= S_IDLE;
      v_d_q        <= VD_PLAY;
      enemy_turn_q <= 1'b0;
      secs_q       <= 3'd0;
      defend_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!ga_q && heroe_seleccionado != 3'd0) begin
            hero_id_q <= heroe_seleccionado;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          hero_hp_q    <= hero_hp_f(hero_id_q);
          enemy_hp_q   <= 5'(ENEMY_HP);
          defend_q     <= 1'b0;
          secs_q       <= 3'(TURN_SECS);
          enemy_turn_q <= 1'b0;
          state_q      <= S_HERO;
        end
        S_HERO: begin
          // an action key beats a same-cycle timeout tick
          if (key_evt_q && key_code_q == KEY_ATTACK) begin
            enemy_hp_q <= sat_sub(enemy_hp_q, atk_dmg);
            state_q    <= S_CHECK;
          end else if (key_evt_q && key_code_q == KEY_DEFEND) begin
            defend_q <= 1'b1;
            state_q  <= S_CHECK;
          end else if (tick) begin
            if (secs_q <= 3'd1) begin
              secs_q       <= 3'd0;
              enemy_turn_q <= 1'b1;
              state_q      <= S_ENEMY;
            end else begin
              secs_q <= secs_q - 3'd1;
            end
          end
        end
        S_ENEMY: begin
          if (tick) begin
            state_q <= S_EACT;
          end
        end
        S_EACT: begin
          hero_hp_q <= sat_sub(hero_hp_q, foe_dmg);
          defend_q  <= 1'b0;
          state_q   <= S_CHECK;
        end
        S_CHECK: begin
          if (enemy_hp_q == 5'd0) begin
            v_d_q   <= VD_WIN;
            state_q <= S_RESULT;
          end else if (hero_hp_q == 5'd0) begin
            v_d_q   <= VD_LOSE;
            state_q <= S_RESULT;
          end else if (enemy_turn_q) begin
            enemy_turn_q <= 1'b0;
            secs_q       <= 3'(TURN_SECS);
            state_q      <= S_HERO;
          end else begin
            enemy_turn_q <= 1'b1;
            state_q      <= S_ENEMY;
          end
        end
        S_RESULT: begin
          state_q <= S_RESULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign v_d        = v_d_q;
  assign hero_hp    = hero_hp_q;
  assign enemy_hp   = enemy_hp_q;
  assign enemy_turn = enemy_turn_q;
  assign secs_left  = secs_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl with TICK_DIV = 4: a vector table of
// single-action games plus hand-written timeout/defend/victory/defeat/reset runs.
module tb_battle_turn_ctrl;

  logic       clk;
  logic       rst_n;
  logic       game_active;
  logic [2:0] heroe_seleccionado;
  logic       keypad_pressed;
  logic [4:0] key;
  logic [1:0] v_d;
  logic [4:0] hero_hp;
  logic [4:0] enemy_hp;
  logic       enemy_turn;
  logic [2:0] secs_left;

  int total;
  int bad;

  logic [7:0] lfsr_m;
  logic [7:0] lfsr_prev;

  typedef struct {
    logic [2:0] hero;
    logic [4:0] k;
    int         exp_hhp;
    int         exp_ehp;
    int         exp_turn;
  } vec_t;

  vec_t vecs[10];

  battle_turn_ctrl #(.TICK_DIV(4), .TURN_SECS(5), .ENEMY_HP(20)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .game_active        (game_active),
    .heroe_seleccionado (heroe_seleccionado),
    .keypad_pressed     (keypad_pressed),
    .key                (key),
    .v_d                (v_d),
    .hero_hp            (hero_hp),
    .enemy_hp           (enemy_hp),
    .enemy_turn         (enemy_turn),
    .secs_left          (secs_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR; lfsr_prev is the value the DUT held during the last edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int a, input int b);
    return (a > b) ? (a - b) : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_game(input logic [2:0] h);
    game_active = 1'b0;
    cyc(2);
    heroe_seleccionado = h;
    game_active = 1'b1;
    cyc(2);
  endtask

  task automatic press(input logic [4:0] k);
    key = k;
    keypad_pressed = 1'b1;
    cyc(1);
    keypad_pressed = 1'b0;
  endtask

  task automatic wait_turn(input logic want, input string nm);
    int n;
    n = 0;
    while (enemy_turn !== want && n < 60) begin
      cyc(1);
      n++;
    end
    chk(nm, int'(enemy_turn), int'(want));
  endtask

  task automatic wait_hp_change(input int old, input string nm);
    int n;
    n = 0;
    while (int'(hero_hp) == old && n < 80) begin
      cyc(1);
      n++;
    end
    chk(nm, int'(int'(hero_hp) != old), 1);
  endtask

  initial begin
    int hp;
    int ehp;
    int n;
    int l;
    int exp_hp;
    bit seen3;

    total = 0;
    bad = 0;
    rst_n = 1'b1;
    game_active = 1'b0;
    heroe_seleccionado = 3'd0;
    keypad_pressed = 1'b0;
    key = 5'd0;

    // hero, key, hero HP after load, enemy HP after action, enemy_turn after action
    vecs[0] = '{3'd1, 5'd1, 10, 17, 1};
    vecs[1] = '{3'd2, 5'd1, 12, 16, 1};
    vecs[2] = '{3'd3, 5'd1, 14, 15, 1};
    vecs[3] = '{3'd4, 5'd1, 16, 18, 1};
    vecs[4] = '{3'd5, 5'd1, 18, 17, 1};
    vecs[5] = '{3'd6, 5'd1, 20, 16, 1};
    vecs[6] = '{3'd7, 5'd1, 22, 15, 1};
    vecs[7] = '{3'd3, 5'd2, 14, 20, 1};
    vecs[8] = '{3'd5, 5'd3, 18, 20, 0};
    vecs[9] = '{3'd2, 5'd0, 12, 20, 0};

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_v_d", v_d, 0);
    chk("rst_hero_hp", hero_hp, 0);
    chk("rst_enemy_hp", enemy_hp, 0);
    chk("rst_enemy_turn", enemy_turn, 0);
    chk("rst_secs_left", secs_left, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 10; i++) begin
      start_game(vecs[i].hero);
      chk($sformatf("vec%0d_hero_hp", i), hero_hp, vecs[i].exp_hhp);
      chk($sformatf("vec%0d_enemy_init", i), enemy_hp, 20);
      press(vecs[i].k);
      cyc(2);
      chk($sformatf("vec%0d_enemy_hp", i), enemy_hp, vecs[i].exp_ehp);
      chk($sformatf("vec%0d_enemy_turn", i), enemy_turn, vecs[i].exp_turn);
    end

    // Timeout then defeat: hero 1 never acts
    start_game(3'd1);
    chk("to_secs_init", secs_left, 5);
    n = 0;
    while (enemy_turn == 1'b0 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("to_enemy_turn", enemy_turn, 1);
    chk("to_window", int'(n >= 16 && n <= 22), 1);
    chk("to_enemy_hp", enemy_hp, 20);
    chk("to_secs_zero", secs_left, 0);
    press(5'd1);
    hp = 10;
    for (int r = 0; r < 10 && hp > 0; r++) begin
      wait_hp_change(hp, "lose_hit_seen");
      exp_hp = sat(hp, 2 + int'(lfsr_prev[1:0]));
      chk("lose_hero_hp", hero_hp, exp_hp);
      hp = exp_hp;
    end
    cyc(2);
    chk("lose_hero_zero", hero_hp, 0);
    chk("lose_v_d", v_d, 2);
    chk("lose_enemy_hp", enemy_hp, 20);

    // Defend rounds with hero 7 until a hit with lfsr[1:0] == 3 is seen
    start_game(3'd7);
    hp = 22;
    seen3 = 1'b0;
    for (int r = 0; r < 8 && !seen3; r++) begin
      wait_turn(1'b0, "def_hero_turn");
      press(5'd2);
      wait_hp_change(hp, "def_hit_seen");
      l = int'(lfsr_prev[1:0]);
      exp_hp = sat(hp, (2 + l) / 2);
      chk("def_hero_hp", hero_hp, exp_hp);
      if (l == 3) begin
        chk("def_l3_delta", hp - int'(hero_hp), 2);
        seen3 = 1'b1;
      end
      hp = exp_hp;
    end
    chk("def_enemy_hp", enemy_hp, 20);
    if (!seen3) $display("note: no defended hit with lfsr[1:0]==3 in this run");

    // Victory: hero 7, ATK 5, four attacks
    start_game(3'd7);
    hp = 22;
    ehp = 20;
    for (int a = 0; a < 4; a++) begin
      wait_turn(1'b0, "vic_hero_turn");
      press(5'd1);
      cyc(2);
      ehp = sat(ehp, 5);
      chk("vic_enemy_hp", enemy_hp, ehp);
      if (a < 3) begin
        wait_hp_change(hp, "vic_hit_seen");
        exp_hp = sat(hp, 2 + int'(lfsr_prev[1:0]));
        chk("vic_hero_hp", hero_hp, exp_hp);
        hp = exp_hp;
      end
    end
    chk("vic_v_d", v_d, 1);
    cyc(10);
    chk("vic_v_d_held", v_d, 1);
    chk("vic_enemy_held", enemy_hp, 0);
    chk("vic_hero_held", hero_hp, hp);
    game_active = 1'b0;
    cyc(1);
    chk("vic_v_d_clear", v_d, 0);
    chk("vic_hp_kept", hero_hp, hp);

    // Async reset in the middle of a hero turn
    start_game(3'd3);
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v_d", v_d, 0);
    chk("mid_rst_hero_hp", hero_hp, 0);
    chk("mid_rst_enemy_hp", enemy_hp, 0);
    chk("mid_rst_enemy_turn", enemy_turn, 0);
    chk("mid_rst_secs_left", secs_left, 0);
    game_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // No hero selected: game_active rising must not start a battle
    heroe_seleccionado = 3'd0;
    game_active = 1'b1;
    cyc(5);
    chk("guard_hero_hp", hero_hp, 0);
    chk("guard_enemy_hp", enemy_hp, 20 * 0);
    heroe_seleccionado = 3'd2;
    cyc(4);
    chk("guard_no_edge", hero_hp, 0);
    start_game(3'd2);
    chk("guard_restart", hero_hp, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
